vga_driver: RTL and testbench

VGA_DRIVER -- requirements
Module: vga_driver

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_timing.sv | 63 ++++++
 rtl/vga_driver.sv | 69 ++++++
 tb/tb_vga_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, counter type and colour-bar helper.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int BAR_WIDTH = 80;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic       h_sync;
    logic       v_sync;
    logic [2:0] rgb;
  } vga_out_t;

  // Bar k = h/BAR_WIDTH is painted 7-k, running white down to black across the line.
  function automatic logic [2:0] bar_colour(input cnt_t h_cnt);
    cnt_t bar_idx;
    bar_idx = h_cnt / cnt_t'(BAR_WIDTH);
    return 3'(3'd7 - 3'(bar_idx));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with the visible-region flag.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output cnt_t h_cnt_o,
  output cnt_t v_cnt_o,
  output logic visible_o
);

  localparam cnt_t H_LAST = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam cnt_t H_VIS  = cnt_t'(H_VISIBLE);
  localparam cnt_t V_VIS  = cnt_t'(V_VISIBLE);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Next raster position: the line counter only moves on the pixel edge that wraps the column.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (en_i) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + cnt_t'(1);
        end
      end else begin
        h_cnt_d = h_cnt_q + cnt_t'(1);
      end
    end
  end

  // Counter registers; reset drops the raster back to pixel (0,0) at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o   = h_cnt_q;
  assign v_cnt_o   = v_cnt_q;
  assign visible_o = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

endmodule

// File: rtl/vga_driver.sv
// VGA colour-bar generator: raster counters plus registered sync and colour outputs.
module vga_driver
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic h_sync,
  output logic v_sync,
  output logic red,
  output logic green,
  output logic blue
);

  localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  cnt_t     h_cnt;
  cnt_t     v_cnt;
  logic     visible;
  vga_out_t out_q, out_d;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .en_i     (en),
    .h_cnt_o  (h_cnt),
    .v_cnt_o  (v_cnt),
    .visible_o(visible)
  );

  // Decode sync and colour from the pre-edge counters so all outputs share one cycle of latency.
  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d.h_sync = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
      out_d.v_sync = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
      out_d.rgb    = visible ? bar_colour(h_cnt) : 3'b000;
    end
  end

  // Output registers; reset forces both syncs inactive and the screen black.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '{h_sync: 1'b1, v_sync: 1'b1, rgb: 3'b000};
    end else begin
      out_q <= out_d;
    end
  end

  assign h_sync              = out_q.h_sync;
  assign v_sync              = out_q.v_sync;
  assign {red, green, blue}  = out_q.rgb;

endmodule

// File: tb/tb_vga_driver.sv
// Scoreboard bench for vga_driver: stimulus pushes expected pixels, a monitor pops and compares.
// The vertical frame is shortened (6 visible lines, 12 total) so several frames fit in a short run;
// horizontal timing keeps its full 800-pixel line.
module tb_vga_driver;

  localparam int TB_V_VIS = 6;
  localparam int TB_V_FP  = 2;
  localparam int TB_V_SY  = 2;
  localparam int TB_V_BP  = 2;
  localparam int TB_V_TOT = 12;
  localparam int TB_H_TOT = 800;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic h_sync, v_sync, red, green, blue;

  int testsRun = 0;
  int testsFailed = 0;

  logic [4:0] expQ[$];
  logic [4:0] lastExp = 5'b11000;
  int mh = 0;
  int mv = 0;

  int edgeIdx = 0;
  int hFall[$];
  int hRise[$];
  int vFall[$];
  int vRise[$];
  int hsAtVFall[$];
  logic prevHs = 1'b1;
  logic prevVs = 1'b1;

  // Free-running system clock.
  always #5 clk = ~clk;

  vga_driver #(
    .V_VISIBLE(TB_V_VIS), .V_FRONT(TB_V_FP), .V_SYNC(TB_V_SY), .V_BACK(TB_V_BP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  // Reference decode of one raster position into {h_sync, v_sync, r, g, b}.
  function automatic logic [4:0] expected(input int h, input int v);
    logic hs, vs;
    logic [2:0] c;
    hs = !(h >= 656 && h <= 751);
    vs = !(v >= 8 && v <= 9);
    c  = (h < 640 && v < TB_V_VIS) ? 3'(7 - h / 80) : 3'b000;
    return {hs, vs, c};
  endfunction

  function automatic int qAt(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic checkVal(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic clearMeasure();
    hFall.delete();
    hRise.delete();
    vFall.delete();
    vRise.delete();
    hsAtVFall.delete();
  endtask

  // Hold reset for n cycles with en high, which the design must ignore.
  task automatic resetDut(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    expQ.delete();
    mh = 0;
    mv = 0;
    repeat (n) @(negedge clk);
    clearMeasure();
  endtask

  // Drive n cycles; optionally release reset on the first, optionally toggle en 1/0.
  task automatic applyStimulus(input int n, input bit doRelease, input bit toggle);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (doRelease && i == 0) rst_n = 1'b1;
      en = toggle ? ((i % 2) == 0) : 1'b1;
      if (en) begin
        expQ.push_back(expected(mh, mv));
        if (mh == TB_H_TOT - 1) begin
          mh = 0;
          mv = (mv == TB_V_TOT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [4:0] required);
    checkVal(name, int'({h_sync, v_sync, red, green, blue}), int'(required));
  endtask

  // Monitor: compares every clock edge against the scoreboard, reset state or held value.
  always @(posedge clk) begin : monitor
    logic enS, rstS;
    logic [4:0] act, e;
    enS  = en;
    rstS = rst_n;
    #1;
    act = {h_sync, v_sync, red, green, blue};
    if (!rstS) begin
      edgeIdx = 0;
      checkVal("resetState", int'(act), int'(5'b11000));
      lastExp = 5'b11000;
      prevHs  = 1'b1;
      prevVs  = 1'b1;
    end else begin
      edgeIdx++;
      if (enS) begin
        if (expQ.size() == 0) begin
          checkVal("scoreboardEmpty", 0, 1);
        end else begin
          e = expQ.pop_front();
          checkVal("pixel", int'(act), int'(e));
          lastExp = e;
        end
      end else begin
        checkVal("holdWhileDisabled", int'(act), int'(lastExp));
      end
      if (prevHs && !h_sync) hFall.push_back(edgeIdx);
      if (!prevHs && h_sync) hRise.push_back(edgeIdx);
      if (prevVs && !v_sync) begin
        vFall.push_back(edgeIdx);
        hsAtVFall.push_back(int'(h_sync));
      end
      if (!prevVs && v_sync) vRise.push_back(edgeIdx);
      prevHs = h_sync;
      prevVs = v_sync;
    end
  end

  initial begin
    // Phase A: continuous enable over three shortened frames.
    resetDut(4);
    applyStimulus(30000, 1'b1, 1'b0);
    @(posedge clk); #2;
    checkVal("hFallFirst", qAt(hFall, 0), 657);
    checkVal("hLowWidth", qAt(hRise, 0) - qAt(hFall, 0), 96);
    checkVal("hPeriod", qAt(hFall, 1) - qAt(hFall, 0), 800);
    checkVal("hFallCount", hFall.size(), 37);
    checkVal("vFallFirst", qAt(vFall, 0), 6401);
    checkVal("vLowWidth", qAt(vRise, 0) - qAt(vFall, 0), 1600);
    checkVal("vPeriod", qAt(vFall, 1) - qAt(vFall, 0), 9600);
    checkVal("vPeriod2", qAt(vFall, 2) - qAt(vFall, 1), 9600);
    checkVal("hsHighAtVFall", qAt(hsAtVFall, 0), 1);
    checkVal("frameCount", vFall.size(), 3);

    // Phase B: en toggling every cycle doubles every period.
    resetDut(3);
    applyStimulus(4000, 1'b1, 1'b1);
    @(posedge clk); #2;
    checkVal("hFallFirstHalfRate", qAt(hFall, 0), 1313);
    checkVal("hLowWidthHalfRate", qAt(hRise, 0) - qAt(hFall, 0), 192);
    checkVal("hPeriodHalfRate", qAt(hFall, 1) - qAt(hFall, 0), 1600);

    // Phase C: asynchronous reset at pixel (300,3), then restart from (0,0).
    resetDut(3);
    applyStimulus(2700, 1'b1, 1'b0);
    @(posedge clk); #3;
    checkOutput("preResetPixel", expected(299, 3));
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetImmediate", 5'b11000);
    resetDut(3);
    applyStimulus(700, 1'b1, 1'b0);
    @(posedge clk); #2;
    checkVal("hFallAfterReset", qAt(hFall, 0), 657);
    checkVal("scoreboardDrained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
